mul_iterative_unit: RTL and testbench

- Multi-cycle shift-add multiplier for the execute stage, covering MUL (Rd = Rm*Rs) and MLA (Rd = Rm*Rs + Rn).
- Takes operands from the register-read stage and produces a low-BUS_WIDTH-bit result plus N/Z flags.
- Raises a stall to freeze upstream pipeline registers while running.
- Its one-cycle done_out pulse drives the enable of the downstream result/flag pipeline registers; result_out feeds their data inputs.

---
 rtl/mul_iterative_unit_if.sv | 36 +++
 rtl/mul_iterative_unit.sv | 110 +++++++++++
 tb/tb_mul_iterative_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mul_iterative_unit_if.sv
// mul_iterative_unit_if
//   Groups the request/response signals of the iterative multiplier.
//   master: the issuing logic. It drives start, mode and operands and
//           receives status, the completion pulse and the result.
//   slave : the multiplier itself.
//   Signals:
//     start_in, accumulate_in        request a MUL (0) or an MLA (1)
//     op_a_in, op_b_in, op_c_in      Rm, Rs, Rn operands
//     busy_out, stall_out            status and pipeline freeze request
//     done_out                       one-cycle completion pulse
//     result_out, neg_out, zero_out  registered result and N/Z flags
interface mul_iterative_unit_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 start_in;
  logic                 accumulate_in;
  logic [BUS_WIDTH-1:0] op_a_in;
  logic [BUS_WIDTH-1:0] op_b_in;
  logic [BUS_WIDTH-1:0] op_c_in;
  logic                 busy_out;
  logic                 stall_out;
  logic                 done_out;
  logic [BUS_WIDTH-1:0] result_out;
  logic                 neg_out;
  logic                 zero_out;

  modport master (
    output start_in, accumulate_in, op_a_in, op_b_in, op_c_in,
    input  busy_out, stall_out, done_out, result_out, neg_out, zero_out
  );

  modport slave (
    input  start_in, accumulate_in, op_a_in, op_b_in, op_c_in,
    output busy_out, stall_out, done_out, result_out, neg_out, zero_out
  );
endinterface

// File: rtl/mul_iterative_unit.sv
// mul_iterative_unit
//   Multi-cycle shift-add multiplier for the execute stage (MUL / MLA).
//   It consumes one multiplier bit per RUN cycle. It stops early once the
//   remaining multiplier bits are all zero, so the run takes
//   max(1, msb_index(op_b)+1) cycles.
//   Ports:
//     clk_in    clock, all state changes on the rising edge
//     reset_in  synchronous active-high reset, aborts any operation
//     bus       slave side of mul_iterative_unit_if (see interface header)
module mul_iterative_unit #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  mul_iterative_unit_if.slave   bus
);

  localparam int CNT_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [BUS_WIDTH-1:0] mcand_r;
  logic [BUS_WIDTH-1:0] mplr_r;
  logic [BUS_WIDTH-1:0] acc_r;
  logic [CNT_W-1:0]     count_r;
  logic                 done_r;
  logic [BUS_WIDTH-1:0] result_r;
  logic                 neg_r;
  logic                 zero_r;

  logic [BUS_WIDTH-1:0] acc_nxt_s;
  logic                 run_last_s;

  // Accumulator update for this RUN step and the termination test.
  always_comb begin
    acc_nxt_s  = acc_r;
    run_last_s = 1'b0;
    if (mplr_r[0]) begin
      acc_nxt_s = acc_r + mcand_r;
    end else begin
      acc_nxt_s = acc_r;
    end
    // Terminate when no multiplier bits remain after this shift, or on the last bit.
    run_last_s = (mplr_r[BUS_WIDTH-1:1] == '0) ||
                 (count_r == CNT_W'(BUS_WIDTH - 1));
  end

  // Control FSM plus datapath and registered result/flags.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_r  <= ST_IDLE;
      mcand_r  <= '0;
      mplr_r   <= '0;
      acc_r    <= '0;
      count_r  <= '0;
      done_r   <= 1'b0;
      result_r <= '0;
      neg_r    <= 1'b0;
      zero_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        // DONE accepts a new start just like IDLE, giving back-to-back issue.
        ST_IDLE, ST_DONE: begin
          if (bus.start_in) begin
            mcand_r <= bus.op_a_in;
            mplr_r  <= bus.op_b_in;
            acc_r   <= bus.accumulate_in ? bus.op_c_in : '0;
            count_r <= '0;
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_r   <= acc_nxt_s;
          mcand_r <= mcand_r << 1;
          mplr_r  <= mplr_r >> 1;
          count_r <= count_r + CNT_W'(1);
          if (run_last_s) begin
            state_r  <= ST_DONE;
            done_r   <= 1'b1;
            result_r <= acc_nxt_s;
            neg_r    <= acc_nxt_s[BUS_WIDTH-1];
            zero_r   <= (acc_nxt_s == '0);
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_out   = (state_r == ST_RUN);
  // Combinational on start so the requesting instruction stalls from its first cycle.
  assign bus.stall_out  = (state_r == ST_RUN) | (bus.start_in & (state_r != ST_RUN));
  assign bus.done_out   = done_r;
  assign bus.result_out = result_r;
  assign bus.neg_out    = neg_r;
  assign bus.zero_out   = zero_r;

endmodule

// File: tb/tb_mul_iterative_unit.sv
// tb_mul_iterative_unit
//   Directed-vector bench for mul_iterative_unit with hand-computed
//   expected results, cycle counts and flags.
module tb_mul_iterative_unit;

  logic clk_in;
  logic reset_in;
  int   checks_cnt;
  int   fail_cnt;

  mul_iterative_unit_if #(.BUS_WIDTH(32)) bus ();

  mul_iterative_unit #(.BUS_WIDTH(32)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_cnt++;
    if (observed !== expected) begin
      fail_cnt++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Step one edge at a time until done_out, bounded at 40 edges.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = 0;
    while (bus.done_out !== 1'b1 && edges < 40) begin
      busy_cnt += int'(bus.busy_out);
      @(posedge clk_in); #1;
      edges++;
    end
  endtask

  task automatic drive_start(input logic acc, input logic [31:0] a, b, c);
    bus.start_in      = 1'b1;
    bus.accumulate_in = acc;
    bus.op_a_in       = a;
    bus.op_b_in       = b;
    bus.op_c_in       = c;
  endtask

  task automatic run_op(input string tag, input logic acc, input logic [31:0] a, b, c,
                        input int exp_k, input logic [31:0] exp_res,
                        input logic exp_neg, input logic exp_zero);
    int edges;
    int busy_cnt;
    @(negedge clk_in);
    drive_start(acc, a, b, c);
    #1;
    check_value({tag, "_stall_req"}, 32'(bus.stall_out), 32'd1);
    @(posedge clk_in); #1;
    bus.start_in = 1'b0;
    wait_done(edges, busy_cnt);
    check_value({tag, "_k"}, 32'(edges), 32'(exp_k));
    check_value({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_k));
    check_value({tag, "_result"}, bus.result_out, exp_res);
    check_value({tag, "_neg"}, 32'(bus.neg_out), 32'(exp_neg));
    check_value({tag, "_zero"}, 32'(bus.zero_out), 32'(exp_zero));
    @(posedge clk_in); #1;
    check_value({tag, "_done_pulse_end"}, 32'(bus.done_out), 32'd0);
  endtask

  initial begin
    int edges;
    int busy_cnt;
    int pulses;
    logic [31:0] seen_res;

    checks_cnt        = 0;
    fail_cnt          = 0;
    reset_in          = 1'b1;
    bus.start_in      = 1'b0;
    bus.accumulate_in = 1'b0;
    bus.op_a_in       = 32'd0;
    bus.op_b_in       = 32'd0;
    bus.op_c_in       = 32'd0;
    repeat (3) @(posedge clk_in);
    #1 reset_in = 1'b0;

    // Reset state
    check_value("rst_busy", 32'(bus.busy_out), 32'd0);
    check_value("rst_stall", 32'(bus.stall_out), 32'd0);
    check_value("rst_done", 32'(bus.done_out), 32'd0);
    check_value("rst_result", bus.result_out, 32'd0);
    check_value("rst_neg", 32'(bus.neg_out), 32'd0);
    check_value("rst_zero", 32'(bus.zero_out), 32'd0);

    // 1: MUL 7*6
    run_op("mul7x6", 1'b0, 32'd7, 32'd6, 32'd0, 3, 32'd42, 1'b0, 1'b0);

    // 2: MLA and zero-multiplier cases
    run_op("mla3x4p5", 1'b1, 32'd3, 32'd4, 32'd5, 3, 32'd17, 1'b0, 1'b0);
    run_op("mla_b0", 1'b1, 32'd77, 32'd0, 32'h1234, 1, 32'h1234, 1'b0, 1'b0);
    run_op("mul9x0", 1'b0, 32'd9, 32'd0, 32'h5555, 1, 32'd0, 1'b0, 1'b1);

    // 3: full-width and sign-bit results
    run_op("mul_ffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32, 32'h0000_0001, 1'b0, 1'b0);
    run_op("mul_msbx1", 1'b0, 32'h8000_0000, 32'd1, 32'd0, 1, 32'h8000_0000, 1'b1, 1'b0);
    run_op("mul1xmsb", 1'b0, 32'd1, 32'h8000_0000, 32'd0, 32, 32'h8000_0000, 1'b1, 1'b0);

    // 4: start during RUN is ignored
    @(negedge clk_in);
    drive_start(1'b0, 32'd5, 32'd3, 32'd0);
    @(posedge clk_in); #1;
    bus.start_in = 1'b0;
    @(negedge clk_in);
    drive_start(1'b0, 32'd100, 32'd100, 32'd0);
    #1;
    check_value("ign_stall_run", 32'(bus.stall_out), 32'd1);
    @(posedge clk_in); #1;
    bus.start_in = 1'b0;
    pulses   = 0;
    seen_res = 32'd0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done_out === 1'b1) begin
        pulses++;
        seen_res = bus.result_out;
      end
      @(posedge clk_in); #1;
    end
    check_value("ign_pulses", 32'(pulses), 32'd1);
    check_value("ign_result", seen_res, 32'd15);
    check_value("ign_busy_after", 32'(bus.busy_out), 32'd0);

    // 5: back-to-back issue from DONE
    @(negedge clk_in);
    drive_start(1'b0, 32'd7, 32'd6, 32'd0);
    @(posedge clk_in); #1;
    bus.start_in = 1'b0;
    wait_done(edges, busy_cnt);
    check_value("b2b_first_k", 32'(edges), 32'd3);
    check_value("b2b_first_result", bus.result_out, 32'd42);
    drive_start(1'b0, 32'd2, 32'd8, 32'd0);
    #1;
    check_value("b2b_stall_done", 32'(bus.stall_out), 32'd1);
    @(posedge clk_in); #1;
    bus.start_in = 1'b0;
    check_value("b2b_busy_noidle", 32'(bus.busy_out), 32'd1);
    check_value("b2b_stall_run", 32'(bus.stall_out), 32'd1);
    check_value("b2b_result_hold", bus.result_out, 32'd42);
    wait_done(edges, busy_cnt);
    check_value("b2b_second_k", 32'(edges), 32'd4);
    check_value("b2b_second_result", bus.result_out, 32'd16);
    @(posedge clk_in); #1;

    // 6: reset mid-RUN aborts the operation
    @(negedge clk_in);
    drive_start(1'b0, 32'd3, 32'h0000_FFFF, 32'd0);
    @(posedge clk_in); #1;
    bus.start_in = 1'b0;
    repeat (4) begin
      @(posedge clk_in); #1;
    end
    check_value("abort_busy_before", 32'(bus.busy_out), 32'd1);
    reset_in = 1'b1;
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    check_value("abort_busy", 32'(bus.busy_out), 32'd0);
    check_value("abort_done", 32'(bus.done_out), 32'd0);
    check_value("abort_result", bus.result_out, 32'd0);
    check_value("abort_stall", 32'(bus.stall_out), 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done_out === 1'b1) pulses++;
      @(posedge clk_in); #1;
    end
    check_value("abort_no_done", 32'(pulses), 32'd0);
    run_op("post_abort2x2", 1'b0, 32'd2, 32'd2, 32'd0, 2, 32'd4, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
